// File: rtl/pixels_bank_ctrl_if.sv
// Control bundle between the pixels bank ping-pong controller and its producer/consumer/bank.
interface pixels_bank_ctrl_if #(parameter int CNT_W = 16);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic             out_valid;
  logic             out_done;
  logic             bank_we;
  logic             bank_wr_pos;
  logic             bank_rd_pos;
  logic [1:0]       occupancy;
  logic [CNT_W-1:0] wr_count;
  logic [CNT_W-1:0] rel_count;
  logic             err_underrun;

  modport slave (
    input  flush, in_valid, out_done,
    output in_ready, out_valid, bank_we, bank_wr_pos, bank_rd_pos,
           occupancy, wr_count, rel_count, err_underrun
  );

  modport master (
    output flush, in_valid, out_done,
    input  in_ready, out_valid, bank_we, bank_wr_pos, bank_rd_pos,
           occupancy, wr_count, rel_count, err_underrun
  );
endinterface

// File: rtl/pixels_bank_ctrl.sv
// Ping-pong slot controller for the two-slot pixels vector bank: write/read pointers,
// per-slot full flags, transfer counters and a sticky underrun flag.
module pixels_bank_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  pixels_bank_ctrl_if.slave  bus
);
  logic [1:0]       full;
  logic             wr_ptr, rd_ptr;
  logic [CNT_W-1:0] wr_count, rel_count;
  logic             err_underrun;
  logic             accept, release_slot, underrun;

  // out_valid is gated by rst so the consumer never sees stale slots while held in reset.
  always_comb begin
    bus.in_ready    = ~rst & ~bus.flush & ~full[wr_ptr];
    bus.out_valid   = ~rst & full[rd_ptr];
    accept          = bus.in_valid & bus.in_ready;
    release_slot    = bus.out_done & bus.out_valid & ~bus.flush;
    underrun        = bus.out_done & ~bus.out_valid & ~bus.flush & ~rst;
    bus.bank_we     = accept;
    bus.bank_wr_pos = wr_ptr;
    bus.bank_rd_pos = rd_ptr;
    bus.occupancy   = {1'b0, full[0]} + {1'b0, full[1]};
    bus.wr_count    = wr_count;
    bus.rel_count   = rel_count;
    bus.err_underrun = err_underrun;
  end

  // Write and release never touch the same slot, so both updates to full[] can apply together.
  always_ff @(posedge clk) begin
    if (rst) begin
      full         <= 2'b00;
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
      wr_count     <= '0;
      rel_count    <= '0;
      err_underrun <= 1'b0;
    end else if (bus.flush) begin
      full   <= 2'b00;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (accept) begin
        full[wr_ptr] <= 1'b1;
        wr_ptr       <= ~wr_ptr;
        wr_count     <= wr_count + 1'b1;
      end
      if (release_slot) begin
        full[rd_ptr] <= 1'b0;
        rd_ptr       <= ~rd_ptr;
        rel_count    <= rel_count + 1'b1;
      end
      if (underrun) err_underrun <= 1'b1;
    end
  end
endmodule

// File: tb/tb_pixels_bank_ctrl.sv
// Directed table-driven bench for pixels_bank_ctrl plus ping-pong streaming and counter wrap.
module tb_pixels_bank_ctrl;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pixels_bank_ctrl_if #(.CNT_W(CW)) bus ();
  pixels_bank_ctrl #(.CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  typedef struct {
    logic rst, flush, iv, od;
    logic rdy, ov, we, wp, rp;
    int   occ, wc, rc;
    logic err;
  } vec_t;

  int checks = 0;
  int errors = 0;
  vec_t tbl[21];

  function automatic vec_t mk(logic r, logic f, logic iv, logic od,
                              logic rdy, logic ov, logic we, logic wp, logic rp,
                              int occ, int wc, int rc, logic err);
    vec_t v;
    v.rst = r; v.flush = f; v.iv = iv; v.od = od;
    v.rdy = rdy; v.ov = ov; v.we = we; v.wp = wp; v.rp = rp;
    v.occ = occ; v.wc = wc; v.rc = rc; v.err = err;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic f, input logic iv, input logic od);
    @(negedge clk);
    rst = r; bus.flush = f; bus.in_valid = iv; bus.out_done = od;
    #1;
  endtask

  initial begin
    //            rst fl iv od  rdy ov we wp rp occ wc rc err
    tbl[0]  = mk(1, 0, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(0, 0, 1, 0,  1, 0, 1, 0, 0, 0, 0, 0, 0);
    tbl[3]  = mk(0, 0, 1, 0,  1, 1, 1, 1, 0, 1, 1, 0, 0);
    tbl[4]  = mk(0, 0, 1, 0,  0, 1, 0, 0, 0, 2, 2, 0, 0);
    tbl[5]  = mk(0, 0, 1, 1,  0, 1, 0, 0, 0, 2, 2, 0, 0);
    tbl[6]  = mk(0, 0, 1, 0,  1, 1, 1, 0, 1, 1, 2, 1, 0);
    tbl[7]  = mk(0, 0, 0, 0,  0, 1, 0, 1, 1, 2, 3, 1, 0);
    tbl[8]  = mk(0, 0, 0, 1,  0, 1, 0, 1, 1, 2, 3, 1, 0);
    tbl[9]  = mk(0, 0, 0, 1,  1, 1, 0, 1, 0, 1, 3, 2, 0);
    tbl[10] = mk(0, 0, 1, 1,  1, 0, 1, 1, 1, 0, 3, 3, 0);
    tbl[11] = mk(0, 1, 1, 0,  0, 1, 0, 0, 1, 1, 4, 3, 1);
    tbl[12] = mk(0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 4, 3, 1);
    tbl[13] = mk(0, 1, 0, 1,  0, 0, 0, 0, 0, 0, 4, 3, 1);
    tbl[14] = mk(1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 4, 3, 1);
    tbl[15] = mk(0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[16] = mk(0, 0, 1, 0,  1, 0, 1, 0, 0, 0, 0, 0, 0);
    tbl[17] = mk(0, 1, 1, 0,  0, 1, 0, 1, 0, 1, 1, 0, 0);
    tbl[18] = mk(0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 1, 0, 0);
    tbl[19] = mk(1, 1, 1, 0,  0, 0, 0, 0, 0, 0, 1, 0, 0);
    tbl[20] = mk(0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0);

    rst = 1'b1; bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_done = 1'b0;
    #1;
    chk("rst_in_ready", -1, bus.in_ready, 0);
    chk("rst_bank_we", -1, bus.bank_we, 0);
    chk("rst_out_valid", -1, bus.out_valid, 0);

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].flush, tbl[i].iv, tbl[i].od);
      chk("in_ready", i, bus.in_ready, tbl[i].rdy);
      chk("out_valid", i, bus.out_valid, tbl[i].ov);
      chk("bank_we", i, bus.bank_we, tbl[i].we);
      chk("wr_pos", i, bus.bank_wr_pos, tbl[i].wp);
      chk("rd_pos", i, bus.bank_rd_pos, tbl[i].rp);
      chk("occupancy", i, bus.occupancy, tbl[i].occ);
      chk("wr_count", i, bus.wr_count, tbl[i].wc);
      chk("rel_count", i, bus.rel_count, tbl[i].rc);
      chk("err_underrun", i, bus.err_underrun, tbl[i].err);
    end

    // Ping-pong: first cycle writes only, then write+release every cycle.
    for (int k = 0; k < 10; k++) begin
      drive(0, 0, 1, k != 0);
      chk("pp_we", 100 + k, bus.bank_we, 1);
      chk("pp_wr_pos", 100 + k, bus.bank_wr_pos, k % 2);
      if (k != 0) begin
        chk("pp_rd_pos", 100 + k, bus.bank_rd_pos, (k - 1) % 2);
        chk("pp_occ", 100 + k, bus.occupancy, 1);
      end
    end
    drive(0, 0, 0, 0);
    chk("pp_wr_count", 110, bus.wr_count, 10);
    chk("pp_rel_count", 110, bus.rel_count, 9);
    chk("pp_occ_end", 110, bus.occupancy, 1);
    chk("pp_rd_pos_end", 110, bus.bank_rd_pos, 1);

    // Continue streaming until both counters wrap past 2^CW-1.
    for (int k = 0; k < 7; k++) begin
      drive(0, 0, 1, 1);
      chk("wrap_we", 200 + k, bus.bank_we, 1);
      chk("wrap_ov", 200 + k, bus.out_valid, 1);
    end
    drive(0, 0, 0, 0);
    chk("wrap_wr_count", 210, bus.wr_count, 1);
    chk("wrap_rel_count", 210, bus.rel_count, 0);
    chk("wrap_occ", 210, bus.occupancy, 1);
    chk("wrap_err", 210, bus.err_underrun, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
